// File: rtl/shadow_stack_unit_pkg.sv
// Shared types for the return-address shadow stack: FSM states, the
// branch-unit event bundle and the return-address increment helper.
package shadow_stack_unit_pkg;

    localparam int SS_VLEN = 32;

    typedef enum logic [1:0] {
        SS_IDLE    = 2'd0,
        SS_CHECK   = 2'd1,
        SS_CRASHED = 2'd2
    } ss_state_e;

    // Single bundle the branch unit can drive per resolved control-flow event.
    typedef struct packed {
        logic               valid;
        logic               is_call;
        logic               is_ret;
        logic [SS_VLEN-1:0] pc;
        logic               is_compressed;
        logic [SS_VLEN-1:0] target;
    } ss_event_t;

    function automatic logic [2:0] ss_ret_inc(input logic is_compressed);
        return is_compressed ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/shadow_stack_unit_lifo_mem.sv
// Circular DEPTH x VLEN register file: push writes at sp, pop retreats sp,
// replace overwrites the current top in place. Wrap-around is implicit.
module shadow_stack_unit_lifo_mem
    import shadow_stack_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int VLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            replace_i,
    input  logic [VLEN-1:0] wdata_i,
    output logic [VLEN-1:0] top_o
);

    localparam int            AW  = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0]   r_sp;
    logic [AW-1:0]   w_sp_m1;
    logic [VLEN-1:0] r_mem [DEPTH];

    assign w_sp_m1 = r_sp - ONE;
    assign top_o   = r_mem[w_sp_m1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sp <= '0;
        end else if (clr_i) begin
            r_sp <= '0;
        end else if (push_i) begin
            r_sp <= r_sp + ONE;
        end else if (pop_i) begin
            r_sp <= w_sp_m1;
        end
    end

    // Entry storage carries no reset; occupancy in the parent tells which are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_sp] <= wdata_i;
        end else if (replace_i) begin
            r_mem[w_sp_m1] <= wdata_i;
        end
    end

endmodule

// File: rtl/shadow_stack_unit.sv
// Return-address shadow stack downstream of the branch unit: calls push,
// returns are checked one cycle later against the popped entry.
module shadow_stack_unit
    import shadow_stack_unit_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int VLEN            = 32,
    parameter bit UNDERFLOW_CRASH = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic                   valid_i,
    input  logic                   is_call_i,
    input  logic                   is_ret_i,
    input  logic [VLEN-1:0]        pc_i,
    input  logic                   is_compressed_i,
    input  logic [VLEN-1:0]        target_i,
    output logic                   crash_o,
    output logic [VLEN-1:0]        crash_pc_o,
    output logic [$clog2(DEPTH):0] depth_o,
    output logic                   overflow_o
);

    localparam int            OW     = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] OCC_1  = OW'(1);
    localparam logic [OW-1:0] OCC_MX = OW'(DEPTH);

    ss_state_e       r_state;
    ss_state_e       w_state_nxt;
    logic [OW-1:0]   r_occ;
    logic            r_overflow;
    logic [VLEN-1:0] r_crash_pc;

    logic            w_act;
    logic            w_call;
    logic            w_ret;
    logic            w_empty;
    logic            w_full;
    logic            w_do_push;
    logic            w_do_pop;
    logic            w_do_repl;
    logic            w_fail;
    logic [VLEN-1:0] w_ret_addr;
    logic [VLEN-1:0] w_top;

    logic            r_uflow_p1;
    logic [VLEN-1:0] r_entry_p1;
    logic [VLEN-1:0] r_target_p1;
    logic [VLEN-1:0] r_pc_p1;

    // A frozen (crashed) stack and a clearing cycle both swallow the event.
    assign w_act      = valid_i & ~clr_i & (r_state != SS_CRASHED);
    assign w_call     = w_act & is_call_i;
    assign w_ret      = w_act & is_ret_i;
    assign w_empty    = (r_occ == '0);
    assign w_full     = (r_occ == OCC_MX);
    assign w_ret_addr = pc_i + VLEN'(ss_ret_inc(is_compressed_i));

    // A swap on an empty stack degenerates to underflow plus a plain push.
    assign w_do_push  = w_call & (~w_ret | w_empty);
    assign w_do_pop   = w_ret & ~w_call & ~w_empty;
    assign w_do_repl  = w_call & w_ret & ~w_empty;

    shadow_stack_unit_lifo_mem #(
        .DEPTH (DEPTH),
        .VLEN  (VLEN)
    ) u_lifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .push_i    (w_do_push),
        .pop_i     (w_do_pop),
        .replace_i (w_do_repl),
        .wdata_i   (w_ret_addr),
        .top_o     (w_top)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else if (clr_i) begin
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_call & ~w_ret & w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_do_push & ~w_full) begin
                r_occ <= r_occ + OCC_1;
            end else if (w_do_pop) begin
                r_occ <= r_occ - OCC_1;
            end
        end
    end

    // Stage p0 -> p1: capture the popped entry, target and pc of each return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_uflow_p1 <= 1'b0;
        end else if (w_ret) begin
            r_uflow_p1 <= w_empty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_ret) begin
            r_entry_p1  <= w_top;
            r_target_p1 <= target_i;
            r_pc_p1     <= pc_i;
        end
    end

    // Stage p1: compare. Underflow after an overflow is blamed on lost entries.
    assign w_fail = en_i & (r_uflow_p1 ? (UNDERFLOW_CRASH & ~r_overflow)
                                       : (r_entry_p1 != r_target_p1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SS_IDLE: begin
                if (w_ret) begin
                    w_state_nxt = SS_CHECK;
                end
            end
            SS_CHECK: begin
                if (w_fail) begin
                    w_state_nxt = SS_CRASHED;
                end else if (w_ret) begin
                    w_state_nxt = SS_CHECK;
                end else begin
                    w_state_nxt = SS_IDLE;
                end
            end
            SS_CRASHED: begin
                w_state_nxt = SS_CRASHED;
            end
            default: begin
                w_state_nxt = SS_IDLE;
            end
        endcase
        if (clr_i) begin
            w_state_nxt = SS_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_crash_pc <= '0;
        end else if (clr_i) begin
            r_crash_pc <= '0;
        end else if ((r_state == SS_CHECK) && (w_state_nxt == SS_CRASHED)) begin
            r_crash_pc <= r_pc_p1;
        end
    end

    assign crash_o    = (r_state == SS_CRASHED);
    assign crash_pc_o = r_crash_pc;
    assign depth_o    = r_occ;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_shadow_stack_unit.sv
// Directed bench for shadow_stack_unit: call/return matching, crash latency,
// overflow attribution, underflow, coroutine swap, back-to-back returns, async reset.
module tb_shadow_stack_unit;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic        clr_i;
    logic        valid_i;
    logic        is_call_i;
    logic        is_ret_i;
    logic [31:0] pc_i;
    logic        is_compressed_i;
    logic [31:0] target_i;
    logic        crash_o;
    logic [31:0] crash_pc_o;
    logic [4:0]  depth_o;
    logic        overflow_o;

    int n_run  = 0;
    int n_fail = 0;

    shadow_stack_unit #(
        .DEPTH           (16),
        .VLEN            (32),
        .UNDERFLOW_CRASH (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .en_i            (en_i),
        .clr_i           (clr_i),
        .valid_i         (valid_i),
        .is_call_i       (is_call_i),
        .is_ret_i        (is_ret_i),
        .pc_i            (pc_i),
        .is_compressed_i (is_compressed_i),
        .target_i        (target_i),
        .crash_o         (crash_o),
        .crash_pc_o      (crash_pc_o),
        .depth_o         (depth_o),
        .overflow_o      (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic c, input logic r, input logic [31:0] pc,
                      input logic cmp, input logic [31:0] tgt);
        valid_i         = 1'b1;
        is_call_i       = c;
        is_ret_i        = r;
        pc_i            = pc;
        is_compressed_i = cmp;
        target_i        = tgt;
        cyc();
        valid_i   = 1'b0;
        is_call_i = 1'b0;
        is_ret_i  = 1'b0;
    endtask

    task automatic clear();
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0;
        is_call_i = 1'b0; is_ret_i = 1'b0; pc_i = '0; is_compressed_i = 1'b0; target_i = '0;
        cyc(); cyc();
        chk("rst_crash", 32'(crash_o), 32'h0);
        chk("rst_crash_pc", crash_pc_o, 32'h0);
        chk("rst_depth", 32'(depth_o), 32'h0);
        chk("rst_overflow", 32'(overflow_o), 32'h0);
        rst_i = 1'b0;
        cyc();

        // matching call/return
        ev(1'b1, 1'b0, 32'h8000_0100, 1'b0, 32'h0);
        chk("t1_depth_call", 32'(depth_o), 32'd1);
        ev(1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h8000_0104);
        chk("t1_depth_ret", 32'(depth_o), 32'd0);
        cyc(); cyc();
        chk("t1_no_crash", 32'(crash_o), 32'h0);

        // compressed call, return checked against pc+4 -> mismatch
        ev(1'b1, 1'b0, 32'h8000_0200, 1'b1, 32'h0);
        ev(1'b0, 1'b1, 32'h8000_0400, 1'b0, 32'h8000_0204);
        chk("t2_crash_n", 32'(crash_o), 32'h0);
        cyc();
        chk("t2_crash_n1", 32'(crash_o), 32'h1);
        chk("t2_crash_pc", crash_pc_o, 32'h8000_0400);
        ev(1'b1, 1'b0, 32'h8000_0500, 1'b0, 32'h0);
        chk("t2_frozen_depth", 32'(depth_o), 32'd0);
        chk("t2_sticky", 32'(crash_o), 32'h1);
        clear();
        chk("t2_clr_crash", 32'(crash_o), 32'h0);
        chk("t2_clr_depth", 32'(depth_o), 32'd0);

        // 18 nested calls on 16 entries, then 18 matching returns
        for (int i = 0; i < 18; i++) ev(1'b1, 1'b0, 32'h1000 + 32'(i * 16), 1'b0, 32'h0);
        chk("t3_depth_full", 32'(depth_o), 32'd16);
        chk("t3_overflow", 32'(overflow_o), 32'h1);
        for (int i = 17; i >= 2; i--) ev(1'b0, 1'b1, 32'h9000, 1'b0, 32'h1004 + 32'(i * 16));
        chk("t3_depth_16ret", 32'(depth_o), 32'd0);
        ev(1'b0, 1'b1, 32'h9010, 1'b0, 32'h1014);
        ev(1'b0, 1'b1, 32'h9020, 1'b0, 32'h1004);
        cyc(); cyc();
        chk("t3_no_crash", 32'(crash_o), 32'h0);
        chk("t3_depth_end", 32'(depth_o), 32'd0);
        chk("t3_overflow_kept", 32'(overflow_o), 32'h1);
        clear();
        chk("t3_clr_overflow", 32'(overflow_o), 32'h0);

        // underflow from reset, enabled then disabled
        do_reset();
        ev(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0123);
        cyc();
        chk("t4_uflow_crash", 32'(crash_o), 32'h1);
        chk("t4_uflow_pc", crash_pc_o, 32'h0000_0500);
        do_reset();
        en_i = 1'b0;
        ev(1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0123);
        cyc(); cyc();
        chk("t4_uflow_en0", 32'(crash_o), 32'h0);
        en_i = 1'b1;

        // coroutine swap, then the new top must be pc+4 of the swap
        do_reset();
        ev(1'b1, 1'b0, 32'h0000_2000, 1'b0, 32'h0);
        ev(1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_2004);
        chk("t5_swap_depth", 32'(depth_o), 32'd1);
        ev(1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3004);
        chk("t5_after_depth", 32'(depth_o), 32'd0);
        cyc(); cyc();
        chk("t5_swap_ok", 32'(crash_o), 32'h0);

        // back-to-back returns: second mismatches
        ev(1'b1, 1'b0, 32'h0000_4000, 1'b0, 32'h0);
        ev(1'b1, 1'b0, 32'h0000_4100, 1'b0, 32'h0);
        ev(1'b0, 1'b1, 32'h0000_4180, 1'b0, 32'h0000_4104);
        chk("t5_b2b_depth1", 32'(depth_o), 32'd1);
        ev(1'b0, 1'b1, 32'h0000_4200, 1'b0, 32'h0000_9999);
        chk("t5_b2b_first_ok", 32'(crash_o), 32'h0);
        cyc();
        chk("t5_b2b_second", 32'(crash_o), 32'h1);
        chk("t5_b2b_pc", crash_pc_o, 32'h0000_4200);
        clear();

        // back-to-back returns: first mismatches
        ev(1'b1, 1'b0, 32'h0000_5000, 1'b0, 32'h0);
        ev(1'b1, 1'b0, 32'h0000_5100, 1'b0, 32'h0);
        ev(1'b0, 1'b1, 32'h0000_5200, 1'b0, 32'h0000_0BAD);
        ev(1'b0, 1'b1, 32'h0000_5300, 1'b0, 32'h0000_5004);
        chk("t5_first_bad", 32'(crash_o), 32'h1);
        chk("t5_first_pc", crash_pc_o, 32'h0000_5200);
        chk("t5_first_depth", 32'(depth_o), 32'd0);
        clear();

        // asynchronous reset while a mismatch is pending in CHECK
        ev(1'b1, 1'b0, 32'h0000_6000, 1'b0, 32'h0);
        ev(1'b0, 1'b1, 32'h0000_6100, 1'b0, 32'h0000_7777);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_async_crash", 32'(crash_o), 32'h0);
        chk("t6_async_depth", 32'(depth_o), 32'd0);
        cyc();
        rst_i = 1'b0;
        cyc(); cyc();
        chk("t6_post_crash", 32'(crash_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/shadow_stack_unit.md
Name: shadow_stack_unit

Overview:
- Hardware return-address shadow stack placed directly downstream of the branch unit.
- Consumes each resolved control-flow event: calls push their return address, returns have their resolved target checked against the top of stack.
- A mismatch or illegal underflow raises a sticky crash request, which the frontend uses to redirect fetch to address 0.
- Complements the in-band return-address scrambling done in the branch unit with an out-of-band integrity check.

Parameters:
- DEPTH, 16, number of stack entries (power of 2, minimum 4)
- VLEN, 32, virtual address width
- UNDERFLOW_CRASH, 1, 1 means a return on an empty, never-overflowed stack raises a crash

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; reset is asynchronous and active-high
- en_i  in  1  checking enable; when 0, push/pop still track but crash_o never sets
- clr_i  in  1  clears crash_o, overflow_o and the stack (debug/software recovery)
- valid_i  in  1  resolved branch valid (one commit per cycle max)
- is_call_i  in  1  JAL/JALR with rd == x1
- is_ret_i  in  1  JALR with rd == x0 and rs1 == x1
- pc_i  in  VLEN  PC of the resolved instruction
- is_compressed_i  in  1  instruction is 16-bit
- target_i  in  VLEN  resolved (decoded) target address
- crash_o  out  1  sticky crash request
- crash_pc_o  out  VLEN  PC of the offending return
- depth_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: at least one entry has been lost to wrap-around

Behaviour:
- Reset (async, rst_i=1): stack pointer and occupancy = 0; crash_o = 0, crash_pc_o = 0, overflow_o = 0; FSM in IDLE; entries need not be cleared.
- Return address: ret_addr = pc_i + (is_compressed_i ? 2 : 4), computed modulo 2^VLEN.
- Push (valid_i & is_call_i & ~is_ret_i):
  - write ret_addr at sp, sp = sp+1 mod DEPTH.
  - occupancy saturates at DEPTH.
  - if occupancy was already DEPTH: oldest entry overwritten, overflow_o <= 1.
- Pop (valid_i & is_ret_i & ~is_call_i):
  - if occupancy > 0: compare target_i with entry[sp-1], sp--, occupancy--.
  - if occupancy == 0: underflow.
- Simultaneous is_call_i & is_ret_i (coroutine swap): pop/compare first, then push the new ret_addr into the same slot; sp and occupancy unchanged. If empty, treat as underflow plus push.
- Compare pipeline, one registered stage:
  - cycle N: capture popped entry, target_i and pc_i into check registers.
  - cycle N+1: compare.
  - crash_o rises at the N+1 clock edge (latency 1 cycle after the return commit).
- FSM:
  - IDLE: on pop or underflow, go to CHECK.
  - CHECK: mismatch with en_i=1 goes to CRASHED (crash_o=1, crash_pc_o=captured pc). Otherwise go to IDLE, or stay in CHECK if a new pop arrives the same cycle (back-to-back returns supported, one per cycle).
  - CRASHED: further pushes/pops ignored; stack frozen. Only clr_i or reset leaves.
- Underflow:
  - crashes only if UNDERFLOW_CRASH=1, en_i=1 and overflow_o=0.
  - if overflow_o=1, the underflow is attributed to lost entries: no crash, occupancy stays 0.
- clr_i (synchronous): highest priority after reset. Returns the FSM to IDLE, clears crash_o, overflow_o, sp and occupancy. Any event on valid_i in the same cycle is dropped.
- en_i=0 during CHECK: the compare result is discarded.
- valid_i=0, or neither flag set: no state change.

Decomposition:
- Shared package (ariane_pkg):
  - typedef ss_state_e {SS_IDLE, SS_CHECK, SS_CRASHED}
  - struct ss_event_t {valid, is_call, is_ret, pc, is_compressed, target}, so the branch unit can drive a single bundle.
- One natural sub-module: ss_lifo_mem, a DEPTH x VLEN circular register file with push/pop/replace and wrap-around; the FSM and compare stay in the top.

Test Plan:
- Reset then call at pc 0x80000100 (4-byte), return with target 0x80000104 -> crash_o stays 0, depth_o 1→0.
- Call at pc 0x80000200 compressed, return target 0x80000204 -> crash_o=1 one cycle after the return, crash_pc_o = return PC; later events ignored until clr_i.
- 18 nested calls with DEPTH=16, then 18 matching returns -> overflow_o=1, the first 16 returns match, the last 2 underflow without crash.
- Return on empty stack from reset with UNDERFLOW_CRASH=1, en_i=1 -> crash_o=1; repeat with en_i=0 -> crash_o stays 0.
- Coroutine swap (is_call_i & is_ret_i) with a matching target -> no crash, depth_o unchanged, new top = pc+4; back-to-back returns on consecutive cycles are each checked.
- Assert rst_i asynchronously mid-CHECK with a mismatch pending -> crash_o=0 immediately, depth_o=0, no crash after release.
